// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
// Select codes are the slice encoding used by the sequencer's callers.
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } seq_state_t;

  localparam logic [3:0] SEL_PASS_A = 4'd0;
  localparam logic [3:0] SEL_OR     = 4'd1;
  localparam logic [3:0] SEL_AND    = 4'd4;
  localparam logic [3:0] SEL_ADD    = 4'd6;

endpackage

// File: rtl/alu_seq_nibble_mux.sv
// Selects one 4-bit slice of a wide operand by nibble index.
// Out-of-range indices yield zero.
import alu_seq_pkg::*;

module alu_seq_nibble_mux #(
  parameter int NIBBLES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NIBBLES*NIBBLE_W-1:0] data,
  input  logic [IDX_W-1:0]            idx,
  output logic [NIBBLE_W-1:0]         nib
);

  always_comb begin
    nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i))
        nib = data[i*NIBBLE_W +: NIBBLE_W];
    end
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Issues a wide op to an external 4-bit ALU slice, LSB nibble first.
// ALU_SEQ_B2B_EN: accept a new request in the same edge as the response.
import alu_seq_pkg::*;

module alu_nibble_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W      = NIBBLES * NIBBLE_W,
  localparam int IDX_W  = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [3:0]   req_sel,
  input  logic         req_m,
  input  logic         req_cin,
  output logic [3:0]   alu_in1,
  output logic [3:0]   alu_in2,
  output logic [3:0]   alu_sel,
  output logic         alu_cin,
  output logic         alu_m,
  input  logic [3:0]   alu_out,
  input  logic         alu_cout,
  input  logic         alu_comparator,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_cout,
  output logic         rsp_equal
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [3:0]       sel_reg;
  logic             m_reg;
  logic             carry_reg;
  logic             eq_reg;
  logic [W-1:0]     result;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             issuing;
  logic             accept;

  alu_seq_nibble_mux #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_mux_a (
    .data (a_reg),
    .idx  (idx),
    .nib  (nib_a)
  );

  alu_seq_nibble_mux #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_mux_b (
    .data (b_reg),
    .idx  (idx),
    .nib  (nib_b)
  );

`ifdef ALU_SEQ_B2B_EN
  assign req_ready = (state == IDLE) ||
                     ((state == DONE) && rsp_ready);
`else
  assign req_ready = (state == IDLE);
`endif

  assign accept    = req_valid && req_ready;
  assign issuing   = (state == ISSUE);
  assign rsp_valid = (state == DONE);

  // Slice drive comes only from state registers; idle values outside ISSUE.
  assign alu_in1 = issuing ? nib_a   : 4'h0;
  assign alu_in2 = issuing ? nib_b   : 4'h0;
  assign alu_sel = issuing ? sel_reg : 4'h0;
  assign alu_m   = issuing ? m_reg   : 1'b1;
  assign alu_cin = issuing && !m_reg && carry_reg;

  assign rsp_result = result;
  assign rsp_cout   = carry_reg;
  assign rsp_equal  = eq_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sel_reg   <= '0;
      m_reg     <= 1'b1;
      carry_reg <= 1'b0;
      eq_reg    <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        ISSUE: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i))
              result[i*NIBBLE_W +: NIBBLE_W] <= alu_out;
          end
          carry_reg <= alu_cout;
          eq_reg    <= eq_reg && alu_comparator;
          if (idx == LAST) begin
            state <= DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: ;
      endcase
      // A load overrides the DONE->IDLE step when back-to-back is enabled.
      if (accept) begin
        state     <= ISSUE;
        idx       <= '0;
        a_reg     <= req_a;
        b_reg     <= req_b;
        sel_reg   <= req_sel;
        m_reg     <= req_m;
        carry_reg <= req_cin;
        eq_reg    <= 1'b1;
      end
    end
  end

endmodule
